// File: rtl/otbn_keccak_theta_unit_if.sv
// Handshake and readout bus of the Keccak theta-parity unit.
// The master side drives lanes and readout selects.
// The slave side is the theta unit, which returns ready/status and the slotted D word.
interface otbn_keccak_theta_unit_if;
  logic         start_i;
  logic         lane_valid_i;
  logic [2:0]   lane_x_i;
  logic [63:0]  lane_i;
  logic         lane_ready_o;
  logic         busy_o;
  logic         d_valid_o;
  logic [2:0]   d_sel_i;
  logic [1:0]   d_w_sel_i;
  logic [255:0] d_o;
  logic         err_o;

  modport master (
    output start_i, lane_valid_i, lane_x_i, lane_i, d_sel_i, d_w_sel_i,
    input  lane_ready_o, busy_o, d_valid_o, d_o, err_o
  );

  modport slave (
    input  start_i, lane_valid_i, lane_x_i, lane_i, d_sel_i, d_w_sel_i,
    output lane_ready_o, busy_o, d_valid_o, d_o, err_o
  );
endinterface

// File: rtl/otbn_keccak_theta_unit.sv
// Sequential Keccak theta-parity stage.
// - Accumulates the column parities C[x] from 25 lanes, one lane per cycle.
// - Then computes D[x] = C[x-1] ^ rotl(C[x+1],1), one D per cycle.
// - D[x] is presented in a selectable 64-bit slot of a 256-bit word.
// Optional feature macro: OTBN_KECCAK_THETA_COLCHECK_EN adds per-column lane
// counters. These drive a sticky err_o on column overflow or an out-of-range x.
module otbn_keccak_theta_unit (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  otbn_keccak_theta_unit_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, DONE} state_e;

  state_e       state_q, state_d;
  logic [63:0]  c_q [5];
  logic [63:0]  d_q [5];
  logic [4:0]   cnt_q;
  logic [2:0]   k_q;
  logic         lane_ready_q, busy_q, d_valid_q;

  logic         start_ok;
  logic         accept;
  logic         x_ok;
  logic         last_lane;
  logic [2:0]   k_m1, k_p1;
  logic [63:0]  theta_d;
  logic [255:0] d_word;

  // A start pulse is ignored while D is being computed.
  assign start_ok  = bus.start_i && (state_q != COMPUTE);
  assign accept    = bus.lane_valid_i && (state_q == ACCUM);
  assign x_ok      = (bus.lane_x_i <= 3'd4);
  assign last_lane = accept && x_ok && (cnt_q == 5'd24) && !bus.start_i;

  assign k_m1    = (k_q == 3'd0) ? 3'd4 : (k_q - 3'd1);
  assign k_p1    = (k_q == 3'd4) ? 3'd0 : (k_q + 3'd1);
  assign theta_d = c_q[k_m1] ^ {c_q[k_p1][62:0], c_q[k_p1][63]};

  // Next-state selection for the accumulate/compute sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = ACCUM;
      ACCUM:   if (bus.start_i) state_d = ACCUM;
               else if (last_lane) state_d = COMPUTE;
      COMPUTE: if (k_q == 3'd4) state_d = DONE;
      DONE:    if (bus.start_i) state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, registered status outputs, parity accumulation and D computation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      lane_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      d_valid_q    <= 1'b0;
      cnt_q        <= 5'd0;
      k_q          <= 3'd0;
      for (int i = 0; i < 5; i++) begin
        c_q[i] <= 64'd0;
        d_q[i] <= 64'd0;
      end
    end else begin
      state_q      <= state_d;
      lane_ready_q <= (state_d == ACCUM);
      busy_q       <= (state_d == ACCUM) || (state_d == COMPUTE);
      d_valid_q    <= (state_d == DONE);

      if (start_ok) begin
        cnt_q <= 5'd0;
        for (int i = 0; i < 5; i++) c_q[i] <= 64'd0;
      end else if (accept && x_ok) begin
        c_q[bus.lane_x_i] <= c_q[bus.lane_x_i] ^ bus.lane_i;
        cnt_q             <= cnt_q + 5'd1;
      end

      if (state_q == COMPUTE) begin
        d_q[k_q] <= theta_d;
        k_q      <= k_q + 3'd1;
      end else begin
        k_q      <= 3'd0;
      end
    end
  end

`ifdef OTBN_KECCAK_THETA_COLCHECK_EN
  logic [2:0] col_cnt_q [5];
  logic       err_q;

  // Per-column lane counts; the error flag is sticky until start or reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      for (int i = 0; i < 5; i++) col_cnt_q[i] <= 3'd0;
    end else if (start_ok) begin
      err_q <= 1'b0;
      for (int i = 0; i < 5; i++) col_cnt_q[i] <= 3'd0;
    end else if (accept) begin
      if (!x_ok) begin
        err_q <= 1'b1;
      end else if (col_cnt_q[bus.lane_x_i] == 3'd5) begin
        err_q <= 1'b1;
      end else begin
        col_cnt_q[bus.lane_x_i] <= col_cnt_q[bus.lane_x_i] + 3'd1;
      end
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  // Slotted readout, visible only once every D register is final.
  always_comb begin
    d_word = '0;
    if (d_valid_q && (bus.d_sel_i <= 3'd4)) begin
      d_word = {192'd0, d_q[bus.d_sel_i]} << {bus.d_w_sel_i, 6'd0};
    end
  end

  assign bus.lane_ready_o = lane_ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.d_valid_o    = d_valid_q;
  assign bus.d_o          = d_word;

endmodule

// File: tb/tb_otbn_keccak_theta_unit.sv
// Self-checking bench for otbn_keccak_theta_unit.
// A lane-level reference model derives the expected outputs, and a negedge
// process compares every output on every cycle.
module tb_otbn_keccak_theta_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  otbn_keccak_theta_unit_if bus ();

  otbn_keccak_theta_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 collecting lanes, 2 computing, 3 D available
  int          m_phase;
  int          m_left;
  int          m_n;
  int          m_col [5];
  bit          m_err;
  logic [63:0] cm [5];
  logic [63:0] dm [5];

  function automatic logic [63:0] rotl1(input logic [63:0] v);
    return (v << 1) | (v >> 63);
  endfunction

  task automatic model_clear();
    m_n = 0;
    m_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cm[i] = '0;
      m_col[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left = 0;
      model_clear();
      for (int i = 0; i < 5; i++) dm[i] = '0;
    end else begin
      case (m_phase)
        0: if (bus.start_i) begin model_clear(); m_phase = 1; end
        1: begin
          if (bus.start_i) begin
            model_clear();
          end else if (bus.lane_valid_i) begin
            if (bus.lane_x_i <= 4) begin
              if (m_col[bus.lane_x_i] >= 5) m_err = 1'b1;
              m_col[bus.lane_x_i]++;
              cm[bus.lane_x_i] ^= bus.lane_i;
              m_n++;
              if (m_n == 25) begin
                m_phase = 2;
                m_left = 5;
              end
            end else begin
              m_err = 1'b1;
            end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            for (int x = 0; x < 5; x++) dm[x] = cm[(x + 4) % 5] ^ rotl1(cm[(x + 1) % 5]);
            m_phase = 3;
          end
        end
        default: if (bus.start_i) begin model_clear(); m_phase = 1; end
      endcase
    end
  end

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  bit colcheck_build;
  initial begin
`ifdef OTBN_KECCAK_THETA_COLCHECK_EN
    colcheck_build = 1'b1;
`else
    colcheck_build = 1'b0;
`endif
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [255:0] exp_d;
      exp_d = '0;
      if (m_phase == 3 && bus.d_sel_i <= 4)
        exp_d = {192'd0, dm[bus.d_sel_i]} << (64 * bus.d_w_sel_i);
      cmp("lane_ready", {255'd0, bus.lane_ready_o}, {255'd0, m_phase == 1});
      cmp("busy",       {255'd0, bus.busy_o},       {255'd0, (m_phase == 1) || (m_phase == 2)});
      cmp("d_valid",    {255'd0, bus.d_valid_o},    {255'd0, m_phase == 3});
      cmp("err",        {255'd0, bus.err_o},        {255'd0, colcheck_build && m_err});
      cmp("d_o",        bus.d_o,                    exp_d);
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0]  lx [25];
  logic [63:0] lv [25];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic send(input logic [2:0] x, input logic [63:0] v);
    bus.lane_valid_i = 1'b1;
    bus.lane_x_i     = x;
    bus.lane_i       = v;
    bus.d_sel_i      = 3'($urandom_range(0, 7));
    bus.d_w_sel_i    = 2'($urandom_range(0, 3));
    step();
    bus.lane_valid_i = 1'b0;
    bus.lane_i       = {$urandom, $urandom};
    bus.lane_x_i     = 3'($urandom_range(0, 7));
  endtask

  // mode 0: all zero, 1: one x=1 lane = 1, 2: one x=1 lane = MSB, 3: random
  task automatic gen_lanes(input int mode);
    int j;
    logic [2:0]  tx;
    for (int i = 0; i < 25; i++) begin
      lx[i] = 3'(i % 5);
      lv[i] = (mode == 3) ? {$urandom, $urandom} : 64'd0;
    end
    for (int i = 24; i > 0; i--) begin
      j = $urandom_range(0, i);
      tx = lx[i]; lx[i] = lx[j]; lx[j] = tx;
    end
    for (int i = 0; i < 25; i++) begin
      if (lx[i] == 3'd1 && mode == 1) begin lv[i] = 64'h1; break; end
      if (lx[i] == 3'd1 && mode == 2) begin lv[i] = 64'h8000_0000_0000_0000; break; end
    end
  endtask

  // Sends the prepared 25 lanes, then checks d_valid timing exactly.
  task automatic run_full(input bit stalls, input bit bad_lane, input bit start_mid);
    for (int i = 0; i < 25; i++) begin
      if (stalls) repeat ($urandom_range(0, 2)) step();
      if (bad_lane && i == 12) send(3'd7, 64'hDEAD_BEEF_0123_4567);
      send(lx[i], lv[i]);
    end
    for (int j = 1; j <= 5; j++) begin
      if (j == 1 && start_mid) bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      cmp($sformatf("latency_dvalid_%0d", j), {255'd0, bus.d_valid_o}, {255'd0, j == 5});
    end
  endtask

  task automatic sweep_readout();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        #1;
        bus.d_sel_i   = 3'(s);
        bus.d_w_sel_i = 2'(w);
      end
    end
    step();
  endtask

  task automatic read_d(input logic [2:0] s, input logic [1:0] w, output logic [255:0] v);
    bus.d_sel_i   = s;
    bus.d_w_sel_i = w;
    #1;
    v = bus.d_o;
  endtask

  logic [255:0] rd;
  logic [255:0] exp_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.lane_valid_i = 1'b0;
    bus.lane_x_i = '0;
    bus.lane_i = '0;
    bus.d_sel_i = '0;
    bus.d_w_sel_i = '0;
    step();
    step();
    chk_en = 1'b1;
    cmp("reset_lane_ready", {255'd0, bus.lane_ready_o}, 256'd0);
    cmp("reset_busy",       {255'd0, bus.busy_o},       256'd0);
    cmp("reset_d_valid",    {255'd0, bus.d_valid_o},    256'd0);
    cmp("reset_err",        {255'd0, bus.err_o},        256'd0);
    cmp("reset_d_o",        bus.d_o,                    256'd0);
    rst_n = 1'b1;
    step();

    // all-zero lanes
    pulse_start();
    cmp("ready_after_start", {255'd0, bus.lane_ready_o}, 256'd1);
    gen_lanes(0);
    run_full(1'b0, 1'b0, 1'b0);
    sweep_readout();

    // single x=1 lane = 1
    pulse_start();
    gen_lanes(1);
    run_full(1'b0, 1'b0, 1'b0);
    cmp("model_D0_one", {192'd0, dm[0]}, 256'h2);
    cmp("model_D2_one", {192'd0, dm[2]}, 256'h1);
    read_d(3'd0, 2'd3, rd);
    cmp("lit_D0_slot3", rd, {64'h2, 192'd0});
    read_d(3'd2, 2'd0, rd);
    cmp("lit_D2_slot0", rd, 256'h1);
    read_d(3'd4, 2'd1, rd);
    cmp("lit_D4_zero", rd, 256'd0);
    sweep_readout();

    // rotation wrap
    pulse_start();
    gen_lanes(2);
    run_full(1'b0, 1'b0, 1'b0);
    read_d(3'd0, 2'd0, rd);
    cmp("lit_wrap_D0", rd, 256'h1);
    read_d(3'd2, 2'd1, rd);
    cmp("lit_wrap_D2", rd, {128'd0, 64'h8000_0000_0000_0000, 64'd0});
    sweep_readout();

    // stalls plus an x=7 lane
    pulse_start();
    gen_lanes(3);
    run_full(1'b1, 1'b1, 1'b0);
    exp_err = {255'd0, colcheck_build};
    cmp("lit_err_badx", {255'd0, bus.err_o}, exp_err);
    sweep_readout();

    // restart after 10 accepts, then fresh lanes with start pulsed in COMPUTE
    pulse_start();
    for (int i = 0; i < 10; i++) send(3'($urandom_range(0, 4)), {$urandom, $urandom});
    pulse_start();
    gen_lanes(3);
    run_full(1'b1, 1'b0, 1'b1);
    sweep_readout();

    // reset in the 3rd COMPUTE cycle
    pulse_start();
    gen_lanes(3);
    for (int i = 0; i < 25; i++) send(lx[i], lv[i]);
    step();
    step();
    rst_n = 1'b0;
    step();
    cmp("midrst_d_valid", {255'd0, bus.d_valid_o}, 256'd0);
    cmp("midrst_busy",    {255'd0, bus.busy_o},     256'd0);
    cmp("midrst_d_o",     bus.d_o,                  256'd0);
    rst_n = 1'b1;
    step();

    // full run after reset
    pulse_start();
    gen_lanes(3);
    run_full(1'b1, 1'b0, 1'b0);
    sweep_readout();

    // six lanes into column 0
    pulse_start();
    for (int i = 0; i < 5; i++) send(3'd0, {$urandom, $urandom});
    cmp("col_five_no_err", {255'd0, bus.err_o}, 256'd0);
    send(3'd0, {$urandom, $urandom});
    cmp("col_six_err", {255'd0, bus.err_o}, exp_err);
    step();

    // a start clears the sticky flag
    pulse_start();
    cmp("err_cleared", {255'd0, bus.err_o}, 256'd0);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
